admo_lsu_ctrl: RTL and testbench
================================

Name: admo_lsu_ctrl

Overview:
- Parametrised load/store unit controller between the admo execute stage and the data-memory port.
- Accepts one byte/half/word (and doubleword at DATA_WIDTH=64) access per request; detects misalignment; generates lane-aligned byte enables and write data; extracts and sign/zero-extends load data.
- Runs a valid/ready memory handshake with a bus timeout. One access is in flight at a time.

Parameters:
- DATA_WIDTH, 32, data bus width; legal values are 32 and 64.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT, 255, maximum cycles in WAIT before aborting; 0 disables the timeout.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  LSU can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_len_i  input  2  00 = byte, 01 = half, 10 = word, 11 = dword (legal only at DATA_WIDTH=64).
- req_unsigned_i  input  1  zero-extend load data.
- req_wdata_i  input  DATA_WIDTH  store data, right-justified.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  misaligned, illegal length, or timeout.
- mem_valid_o  output  1  memory request valid.
- mem_ready_i  input  1  memory completes the access this cycle.
- mem_we_o  output  1  write enable.
- mem_addr_o  output  ADDR_WIDTH  bus-aligned address (low log2(DATA_WIDTH/8) bits zero).
- mem_be_o  output  DATA_WIDTH/8  byte enables.
- mem_wdata_o  output  DATA_WIDTH  lane-shifted store data.
- mem_rdata_i  input  DATA_WIDTH  read data, valid while mem_ready_i=1 on a load.

Behaviour:
- Reset: state=IDLE. req_ready_o=1. rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0. mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0. Timeout counter=0.
- FSM states: IDLE, WAIT, RESP.
- req_ready_o is 1 only in IDLE. A request is accepted when req_valid_i and req_ready_o are both 1; all request fields are registered at acceptance.
- IDLE->WAIT when the accepted request is legal. mem_* outputs are driven from the next cycle.
- IDLE->RESP when the accepted request is illegal: misaligned (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0) or len=11 at DATA_WIDTH=32. No memory access is issued; rsp_err_o=1.
- Byte offset: off = addr mod (DATA_WIDTH/8).
- Byte enables: mem_be_o = base mask << off, where base mask is 1, 3, F or FF for byte, half, word, dword.
- Write data: mem_wdata_o = req_wdata_i << (8*off).
- WAIT: mem_valid_o and all mem_* outputs are held stable until mem_ready_i=1, then go to RESP.
- On a load completion, capture mem_rdata_i >> (8*off), truncate to the access size, then sign-extend (req_unsigned_i=0) or zero-extend (req_unsigned_i=1) to DATA_WIDTH.
- Timeout: the counter increments each WAIT cycle without mem_ready_i. When it reaches TIMEOUT, drop mem_valid_o, go to RESP with rsp_err_o=1 and rdata=0. mem_ready_i arriving on the same cycle as the timeout wins: the access completes normally.
- RESP: rsp_valid_o=1 for exactly one cycle, then return to IDLE. rsp_err_o and rsp_rdata_o are valid only while rsp_valid_o=1 and are 0 otherwise.
- Latency, legal access: accept at cycle N, mem_valid_o at N+1, ready at N+k, rsp_valid_o at N+k+1. Best case is 2 cycles accept-to-response.
- Latency, illegal request: rsp_valid_o at N+1.
- Back-to-back throughput: a new accept is possible in the cycle after RESP.
- No new accept during WAIT or RESP; req_valid_i is ignored there.
- rst_i in WAIT: mem_valid_o drops in the next cycle; the pending access is abandoned with no response. The memory side must tolerate this abort.
- mem_ready_i outside WAIT is ignored.

Test Plan:
- Store byte: addr=0x1003, wdata=0xAB, DATA_WIDTH=32 -> mem_addr_o=0x1000, mem_be_o=1000, mem_wdata_o=0xAB000000; rsp_valid_o pulse with err=0, rdata=0.
- Signed load half: addr=0x2002, mem_rdata_i=0x8001xxxx, unsigned=0 -> rsp_rdata_o=0xFFFF8001. Same access with unsigned=1 -> 0x00008001.
- Misaligned word load at addr=0x3001 -> no mem_valid_o; rsp_valid_o at N+1 with err=1, rdata=0. len=11 at DATA_WIDTH=32 -> same response.
- TIMEOUT=4, mem_ready_i held 0 -> mem_valid_o high for 4 cycles, then rsp err=1. Variant with ready arriving on the 4th cycle -> normal completion, err=0.
- DATA_WIDTH=64, dword load at addr=0x8: mem_be_o=0xFF, rdata passes through unchanged. Byte load at addr=0xD with mem_rdata_i=0x0000_7F00_0000_0000 -> rdata=0x7F.
- Stall then reset: request accepted, ready withheld 3 cycles, rst_i pulsed -> all outputs at reset values next cycle, req_ready_o=1, no rsp_valid_o.

Source files
------------

// File: rtl/admo_lsu_ctrl.sv
// admo load/store unit controller.
// Takes one byte/half/word/dword access per request from the execute stage,
// rejects misaligned or illegal-length requests, lane-aligns store data and
// byte enables onto the data bus, and extracts and extends load data.
// One access is in flight at a time. The memory handshake is guarded by a
// bus timeout.
module admo_lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // request side (execute stage)
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [1:0]              req_len_i,
  input  logic                    req_unsigned_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  // response side
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // data-memory port
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic                  we_q, we_d;
  logic [1:0]            len_q, len_d;
  logic                  uns_q, uns_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Pending response
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Bus timeout counter
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  accept;
  logic                  legal;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] rdata_shifted;

  // Natural alignment check; dword exists only on a 64-bit bus.
  function automatic logic req_legal(input logic [1:0] len, input logic [2:0] a);
    logic ok;
    case (len)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (a[0] == 1'b0);
      2'b10:   ok = (a[1:0] == 2'b00);
      default: ok = (DATA_WIDTH == 64) && (a == 3'b000);
    endcase
    return ok;
  endfunction

  // Unshifted byte-enable mask: 1, 3, F or FF for byte/half/word/dword.
  function automatic logic [NB-1:0] base_mask(input logic [1:0] len);
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b] = (b < (1 << len));
    end
    return m;
  endfunction

  // Truncate right-justified load data to the access size, then sign- or
  // zero-extend it back to the full bus width.
  function automatic logic [DATA_WIDTH-1:0] ext_load(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [1:0]            len,
                                                     input logic                  uns);
    logic [DATA_WIDTH-1:0] res;
    logic                  sgn;
    int                    sz;
    case (len)
      2'b00:   begin sz = 8;          sgn = d[7];            end
      2'b01:   begin sz = 16;         sgn = d[15];           end
      2'b10:   begin sz = 32;         sgn = d[31];           end
      default: begin sz = DATA_WIDTH; sgn = d[DATA_WIDTH-1]; end
    endcase
    if (uns) sgn = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      res[i] = (i < sz) ? d[i] : sgn;
    end
    return res;
  endfunction

  assign accept        = req_valid_i && (state_q == S_IDLE);
  assign legal         = req_legal(req_len_i, req_addr_i[2:0]);
  assign timeout_hit   = (TIMEOUT != 0) && (state_q == S_WAIT) && !mem_ready_i &&
                         (cnt_q == TMO_LAST);
  assign rdata_shifted = mem_rdata_i >> {off_q, 3'b000};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; memory ready wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = legal ? S_WAIT : S_RESP;
      S_WAIT: if (mem_ready_i || timeout_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, response capture and timeout counter next-state
  always_comb begin
    we_d    = we_q;
    len_d   = len_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    if (accept) begin
      we_d    = req_we_i;
      len_d   = req_len_i;
      uns_d   = req_unsigned_i;
      off_d   = req_addr_i[OFF_W-1:0];
      addr_d  = {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      be_d    = base_mask(req_len_i) << req_addr_i[OFF_W-1:0];
      wdata_d = req_wdata_i << {req_addr_i[OFF_W-1:0], 3'b000};
      err_d   = !legal;
      rdata_d = '0;
    end
    if (state_q == S_WAIT) begin
      if (mem_ready_i) begin
        err_d   = 1'b0;
        rdata_d = we_q ? '0 : ext_load(rdata_shifted, len_q, uns_q);
      end else if (timeout_hit) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else if (TIMEOUT != 0) begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      len_q   <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      len_q   <= len_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs: memory port live only in WAIT, response only in RESP
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    if (state_q == S_WAIT) begin
      mem_valid_o = 1'b1;
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_be_o    = be_q;
      mem_wdata_o = wdata_q;
    end
    if (state_q == S_RESP) begin
      rsp_valid_o = 1'b1;
      rsp_err_o   = err_q;
      rsp_rdata_o = rdata_q;
    end
  end

endmodule

// File: tb/tb_admo_lsu_ctrl.sv
// Scoreboard bench for admo_lsu_ctrl: a 32-bit instance with TIMEOUT=4 and a
// 64-bit instance with the default timeout, driven by directed requests.
module tb_admo_lsu_ctrl;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] be;
    logic [63:0] wdata;
    int          len;
  } mem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr    = 0;

  // 32-bit instance signals
  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_req_uns;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [1:0]  a_req_len;
  logic        a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        a_mem_valid, a_mem_ready, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;

  // 64-bit instance signals
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_req_uns;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [1:0]  b_req_len;
  logic        b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;
  logic        b_mem_valid, b_mem_ready, b_mem_we;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_be;

  admo_lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_len_i(a_req_len), .req_unsigned_i(a_req_uns),
    .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
    .mem_valid_o(a_mem_valid), .mem_ready_i(a_mem_ready), .mem_we_o(a_mem_we),
    .mem_addr_o(a_mem_addr), .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(a_mem_rdata)
  );

  admo_lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_len_i(b_req_len), .req_unsigned_i(b_req_uns),
    .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .mem_valid_o(b_mem_valid), .mem_ready_i(b_mem_ready), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(b_mem_rdata)
  );

  rsp_t a_rq[$], b_rq[$];
  mem_t a_mq[$], b_mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitors
  rsp_t a_r, b_r;
  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (a_rq.size() == 0) chk("a_rsp_unexpected", 64'd1, 64'd0);
      else begin
        a_r = a_rq.pop_front();
        chk("a_rsp_err", {63'd0, a_rsp_err}, {63'd0, a_r.err});
        chk("a_rsp_rdata", {32'd0, a_rsp_rdata}, a_r.rdata);
        chk("a_rsp_cycle", 64'(cyc), 64'(a_r.cyc));
      end
    end else begin
      chk("a_rsp_idle_zero", {31'd0, a_rsp_err, a_rsp_rdata}, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid) begin
      if (b_rq.size() == 0) chk("b_rsp_unexpected", 64'd1, 64'd0);
      else begin
        b_r = b_rq.pop_front();
        chk("b_rsp_err", {63'd0, b_rsp_err}, {63'd0, b_r.err});
        chk("b_rsp_rdata", b_rsp_rdata, b_r.rdata);
        chk("b_rsp_cycle", 64'(cyc), 64'(b_r.cyc));
      end
    end else begin
      chk("b_rsp_idle_zero", {63'd0, b_rsp_err} | b_rsp_rdata, 64'd0);
    end
  end

  // Memory-port monitors: field values held for the whole access, and the
  // number of cycles mem_valid_o stays high
  mem_t a_cur, b_cur;
  logic a_pv = 1'b0, b_pv = 1'b0;
  int   a_cnt = 0, b_cnt = 0;

  always @(negedge clk) begin
    if (a_mem_valid && !a_pv) begin
      a_cnt = 0;
      if (a_mq.size() == 0) begin
        chk("a_mem_unexpected", 64'd1, 64'd0);
        a_cur = '{we: 1'b0, addr: 64'd0, be: 64'd0, wdata: 64'd0, len: 0};
      end else a_cur = a_mq.pop_front();
    end
    if (a_mem_valid) begin
      a_cnt++;
      chk("a_mem_we", {63'd0, a_mem_we}, {63'd0, a_cur.we});
      chk("a_mem_addr", {32'd0, a_mem_addr}, a_cur.addr);
      chk("a_mem_be", {60'd0, a_mem_be}, a_cur.be);
      chk("a_mem_wdata", {32'd0, a_mem_wdata}, a_cur.wdata);
    end
    if (!a_mem_valid && a_pv) chk("a_mem_valid_len", 64'(a_cnt), 64'(a_cur.len));
    a_pv = a_mem_valid;
  end

  always @(negedge clk) begin
    if (b_mem_valid && !b_pv) begin
      b_cnt = 0;
      if (b_mq.size() == 0) begin
        chk("b_mem_unexpected", 64'd1, 64'd0);
        b_cur = '{we: 1'b0, addr: 64'd0, be: 64'd0, wdata: 64'd0, len: 0};
      end else b_cur = b_mq.pop_front();
    end
    if (b_mem_valid) begin
      b_cnt++;
      chk("b_mem_we", {63'd0, b_mem_we}, {63'd0, b_cur.we});
      chk("b_mem_addr", {32'd0, b_mem_addr}, b_cur.addr);
      chk("b_mem_be", {56'd0, b_mem_be}, b_cur.be);
      chk("b_mem_wdata", b_mem_wdata, b_cur.wdata);
    end
    if (!b_mem_valid && b_pv) chk("b_mem_valid_len", 64'(b_cnt), 64'(b_cur.len));
    b_pv = b_mem_valid;
  end

  // One request on instance sel (0 = 32-bit, 1 = 64-bit). delay = number of
  // WAIT cycles with ready low before the ready cycle; -1 = never ready.
  task automatic req(input bit sel, input bit we, input logic [31:0] addr,
                     input logic [1:0] len, input bit uns, input logic [63:0] wdata,
                     input int delay, input logic [63:0] rdata, input bit legal,
                     input logic [63:0] exp_be, input logic [63:0] exp_wdata,
                     input logic [63:0] exp_rdata);
    rsp_t r;
    mem_t m;
    int   e;
    e       = cyc;
    r.err   = !legal || (delay < 0);
    r.rdata = exp_rdata;
    r.cyc   = !legal ? e + 1 : (delay < 0 ? e + 5 : e + delay + 2);
    if (sel) b_rq.push_back(r); else a_rq.push_back(r);
    if (legal) begin
      m.we    = we;
      m.addr  = {32'd0, addr & (sel ? ~32'h7 : ~32'h3)};
      m.be    = exp_be;
      m.wdata = exp_wdata;
      m.len   = (delay < 0) ? 4 : delay + 1;
      if (sel) b_mq.push_back(m); else a_mq.push_back(m);
    end
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_len = len;
      b_req_uns = uns; b_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_len = len;
      a_req_uns = uns; a_req_wdata = wdata[31:0];
    end
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    if (legal) begin
      chk(sel ? "b_ready_in_wait" : "a_ready_in_wait",
          {63'd0, sel ? b_req_ready : a_req_ready}, 64'd0);
      if (delay < 0) begin
        repeat (4) step();
      end else begin
        repeat (delay) step();
        if (sel) begin b_mem_ready = 1'b1; b_mem_rdata = rdata; end
        else begin a_mem_ready = 1'b1; a_mem_rdata = rdata[31:0]; end
        step();
        a_mem_ready = 1'b0;
        b_mem_ready = 1'b0;
      end
    end
    step();
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_len = '0;
    a_req_uns = 1'b0; a_req_wdata = '0; a_mem_ready = 1'b0; a_mem_rdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_len = '0;
    b_req_uns = 1'b0; b_req_wdata = '0; b_mem_ready = 1'b0; b_mem_rdata = '0;
    repeat (3) step();

    // Reset state
    chk("a_reset_req_ready", {63'd0, a_req_ready}, 64'd1);
    chk("a_reset_ctrl", {61'd0, a_rsp_valid, a_mem_valid, a_mem_we}, 64'd0);
    chk("a_reset_mem_data", {a_mem_addr, a_mem_wdata} | {60'd0, a_mem_be}, 64'd0);
    chk("a_reset_rsp", {31'd0, a_rsp_err, a_rsp_rdata}, 64'd0);
    chk("b_reset_req_ready", {63'd0, b_req_ready}, 64'd1);
    chk("b_reset_mem", {62'd0, b_mem_valid, b_rsp_valid} | b_mem_wdata, 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // 32-bit instance
    req(0, 1, 32'h1003, 2'b00, 0, 64'h123456AB, 1, 64'hFFFFFFFF, 1, 64'h8, 64'hAB000000, 64'h0);
    req(0, 0, 32'h2002, 2'b01, 0, 64'h0, 2, 64'h80011234, 1, 64'hC, 64'h0, 64'hFFFF8001);
    req(0, 0, 32'h2002, 2'b01, 1, 64'h0, 0, 64'h80011234, 1, 64'hC, 64'h0, 64'h00008001);
    req(0, 0, 32'h3001, 2'b10, 0, 64'h0, 0, 64'h0, 0, 64'h0, 64'h0, 64'h0);
    req(0, 0, 32'h3000, 2'b11, 0, 64'h0, 0, 64'h0, 0, 64'h0, 64'h0, 64'h0);
    req(0, 0, 32'h4000, 2'b10, 0, 64'h0, -1, 64'hDEADBEEF, 1, 64'hF, 64'h0, 64'h0);
    req(0, 0, 32'h4004, 2'b10, 0, 64'h0, 3, 64'hCAFEBABE, 1, 64'hF, 64'h0, 64'hCAFEBABE);
    req(0, 0, 32'h5001, 2'b00, 0, 64'h0, 1, 64'h00008000, 1, 64'h2, 64'h0, 64'hFFFFFF80);
    req(0, 0, 32'h5001, 2'b00, 1, 64'h0, 0, 64'h00008000, 1, 64'h2, 64'h0, 64'h00000080);
    req(0, 1, 32'h6002, 2'b01, 0, 64'h0000BEEF, 0, 64'h0, 1, 64'hC, 64'hBEEF0000, 64'h0);
    req(0, 1, 32'h6001, 2'b01, 0, 64'h0000BEEF, 0, 64'h0, 0, 64'h0, 64'h0, 64'h0);

    // 64-bit instance
    req(1, 0, 32'h8,  2'b11, 0, 64'h0, 1, 64'h0123456789ABCDEF, 1, 64'hFF, 64'h0, 64'h0123456789ABCDEF);
    req(1, 0, 32'hD,  2'b00, 0, 64'h0, 0, 64'h00007F0000000000, 1, 64'h20, 64'h0, 64'h7F);
    req(1, 0, 32'h14, 2'b10, 0, 64'h0, 2, 64'h8000000000000000, 1, 64'hF0, 64'h0, 64'hFFFFFFFF80000000);
    req(1, 0, 32'h14, 2'b11, 0, 64'h0, 0, 64'h0, 0, 64'h0, 64'h0, 64'h0);
    req(1, 1, 32'h12, 2'b01, 0, 64'hFFFFFFFFFFFF1234, 0, 64'h0, 1, 64'h0C, 64'hFFFFFFFF12340000, 64'h0);
    req(1, 1, 32'h10, 2'b11, 0, 64'h1122334455667788, 1, 64'h0, 1, 64'hFF, 64'h1122334455667788, 64'h0);

    // Stall then reset: three WAIT cycles without ready, reset abandons the access
    a_mq.push_back('{we: 1'b1, addr: 64'h7000, be: 64'hF, wdata: 64'h11223344, len: 3});
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h7000; a_req_len = 2'b10;
    a_req_uns = 1'b0; a_req_wdata = 32'h11223344;
    step();
    a_req_valid = 1'b0;
    step();
    step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("a_abort_req_ready", {63'd0, a_req_ready}, 64'd1);
    chk("a_abort_ctrl", {61'd0, a_rsp_valid, a_mem_valid, a_mem_we}, 64'd0);
    chk("a_abort_mem_data", {a_mem_addr, a_mem_wdata} | {60'd0, a_mem_be}, 64'd0);
    repeat (4) step();

    // Back to normal operation after the abort
    req(0, 0, 32'h8000, 2'b10, 1, 64'h0, 0, 64'h89ABCDEF, 1, 64'hF, 64'h0, 64'h89ABCDEF);
    repeat (3) step();

    chk("a_rsp_queue_empty", 64'(a_rq.size()), 64'd0);
    chk("b_rsp_queue_empty", 64'(b_rq.size()), 64'd0);
    chk("a_mem_queue_empty", 64'(a_mq.size()), 64'd0);
    chk("b_mem_queue_empty", 64'(b_mq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
